mips_multicycle_sequencer: RTL and testbench

// - Multi-cycle sequencer for the MIPS datapath.
// - Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// - Turns the combinational control word (RegWrite, MemRead, MemWrite, MULT/DIV, syscall)

---
 rtl/mips_multicycle_sequencer_pkg.sv | 17 +
 rtl/mips_multicycle_sequencer_timeout.sv | 29 ++
 rtl/mips_multicycle_sequencer.sv | 122 ++++++++++++
 tb/tb_mips_multicycle_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_sequencer_pkg.sv
// Shared state encoding for the MIPS multi-cycle sequencer.
package mips_seq_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        RST    = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } seq_state_t;

endpackage

// File: rtl/mips_multicycle_sequencer_timeout.sv
// Wait-cycle counter; expired marks the cycle whose wait would bring the
// count to 2**TO_W-1, i.e. the last cycle in which an ack/done is still accepted.
module seq_timeout_counter #(
    parameter int TO_W = 8
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = ~(TO_W'(1));

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the shared memory port,
// with handshake timeout fault, syscall halt and a retired-instruction counter.
module mips_multicycle_sequencer
    import mips_seq_pkg::*;
#(
    parameter int TO_W  = 8,
    parameter int RET_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   cu_reg_write,
    input  logic                   cu_mem_read,
    input  logic                   cu_mem_write,
    input  logic                   cu_multi,
    input  logic                   cu_halt,
    input  logic                   mem_ack,
    input  logic                   alu_done,
    output logic                   mem_req,
    output logic                   mem_data_sel,
    output logic                   mem_we,
    output logic                   ir_we,
    output logic                   alu_start,
    output logic                   reg_we,
    output logic                   pc_we,
    output logic                   halted,
    output logic                   fault,
    output logic [RET_W-1:0]       retired,
    output logic [SEQ_STATE_W-1:0] state
);

    seq_state_t       state_q, state_d;
    logic             exec_first_q;
    logic [RET_W-1:0] retired_q;
    logic             to_en, to_clr, to_expired;

    seq_timeout_counter #(.TO_W(TO_W)) u_timeout (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    always_comb begin
        state_d = state_q;
        to_en   = 1'b0;
        case (state_q)
            RST:    state_d = FETCH;
            FETCH: begin
                if (mem_ack)         state_d = DECODE;
                else if (to_expired) state_d = FAULT;
                else                 to_en   = 1'b1;
            end
            DECODE: state_d = cu_halt ? HALT : EXEC;
            EXEC: begin
                if (!cu_multi || alu_done)
                    state_d = (cu_mem_read || cu_mem_write) ? MEM : WB;
                else if (to_expired) state_d = FAULT;
                else                 to_en   = 1'b1;
            end
            MEM: begin
                if (mem_ack)         state_d = WB;
                else if (to_expired) state_d = FAULT;
                else                 to_en   = 1'b1;
            end
            WB:     state_d = FETCH;
            HALT:   state_d = HALT;
            FAULT:  state_d = FAULT;
            default: state_d = RST;
        endcase
    end

    assign to_clr = (state_d != state_q);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= RST;
            exec_first_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            exec_first_q <= (state_d == EXEC) && (state_q != EXEC);
            if (state_q == WB) retired_q <= retired_q + RET_W'(1);
        end
    end

    // Moore decode from the state register; only ir_we follows mem_ack directly.
    always_comb begin
        mem_req      = 1'b0;
        mem_data_sel = 1'b0;
        mem_we       = 1'b0;
        ir_we        = 1'b0;
        alu_start    = 1'b0;
        reg_we       = 1'b0;
        pc_we        = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ack;
            end
            EXEC:  alu_start = exec_first_q;
            MEM: begin
                mem_req      = 1'b1;
                mem_data_sel = 1'b1;
                mem_we       = cu_mem_write;
            end
            WB: begin
                reg_we = cu_reg_write;
                pc_we  = 1'b1;
            end
            HALT:  halted = 1'b1;
            FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Directed bench for mips_multicycle_sequencer: vector table plus multi-cycle corner sequences.
module tb_mips_multicycle_sequencer;

    localparam int TO_W  = 4;
    localparam int RET_W = 16;

    logic clk, rst_b;
    logic cu_reg_write, cu_mem_read, cu_mem_write, cu_multi, cu_halt, mem_ack, alu_done;
    logic mem_req, mem_data_sel, mem_we, ir_we, alu_start, reg_we, pc_we, halted, fault;
    logic [RET_W-1:0] retired;
    logic [2:0] state;

    mips_multicycle_sequencer #(.TO_W(TO_W), .RET_W(RET_W)) dut (
        .clk(clk), .rst_b(rst_b),
        .cu_reg_write(cu_reg_write), .cu_mem_read(cu_mem_read), .cu_mem_write(cu_mem_write),
        .cu_multi(cu_multi), .cu_halt(cu_halt), .mem_ack(mem_ack), .alu_done(alu_done),
        .mem_req(mem_req), .mem_data_sel(mem_data_sel), .mem_we(mem_we), .ir_we(ir_we),
        .alu_start(alu_start), .reg_we(reg_we), .pc_we(pc_we), .halted(halted), .fault(fault),
        .retired(retired), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs {rw,rd,wr,multi,halt,ack,done}; outs {req,sel,we,ir,start,rwe,pcwe,halt,fault}
    typedef struct packed {
        logic [6:0] in;
        logic [2:0] st;
        logic [8:0] outs;
    } vec_t;

    vec_t tbl [20];
    int total = 0;
    int bad   = 0;

    function automatic logic [8:0] outs_now();
        return {mem_req, mem_data_sel, mem_we, ir_we, alu_start, reg_we, pc_we, halted, fault};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] v);
        {cu_reg_write, cu_mem_read, cu_mem_write, cu_multi, cu_halt, mem_ack, alu_done} = v;
    endtask

    task automatic apply_v(input string nm, input logic [6:0] in, input logic [2:0] st,
                           input logic [8:0] o);
        set_in(in);
        #1;
        chk({nm, ".state"}, 32'(state), 32'(st));
        chk({nm, ".outs"}, 32'(outs_now()), 32'(o));
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first RST cycle after reset release.
    task automatic do_reset();
        set_in(7'b0);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_exec, n_start, n_wait;

        tbl[0]  = '{7'b1000000, 3'd0, 9'b000000000};
        tbl[1]  = '{7'b1000000, 3'd1, 9'b100000000};
        tbl[2]  = '{7'b1000010, 3'd1, 9'b100100000};
        tbl[3]  = '{7'b1000000, 3'd2, 9'b000000000};
        tbl[4]  = '{7'b1000000, 3'd3, 9'b000010000};
        tbl[5]  = '{7'b1000000, 3'd5, 9'b000001100};
        tbl[6]  = '{7'b1100010, 3'd1, 9'b100100000};
        tbl[7]  = '{7'b1100000, 3'd2, 9'b000000000};
        tbl[8]  = '{7'b1100000, 3'd3, 9'b000010000};
        tbl[9]  = '{7'b1100000, 3'd4, 9'b110000000};
        tbl[10] = '{7'b1100000, 3'd4, 9'b110000000};
        tbl[11] = '{7'b1100000, 3'd4, 9'b110000000};
        tbl[12] = '{7'b1100010, 3'd4, 9'b110000000};
        tbl[13] = '{7'b1100000, 3'd5, 9'b000001100};
        tbl[14] = '{7'b0110010, 3'd1, 9'b100100000};
        tbl[15] = '{7'b0110001, 3'd2, 9'b000000000};
        tbl[16] = '{7'b0110000, 3'd3, 9'b000010000};
        tbl[17] = '{7'b0110010, 3'd4, 9'b111000000};
        tbl[18] = '{7'b0110000, 3'd5, 9'b000000100};
        tbl[19] = '{7'b0000000, 3'd1, 9'b100000000};

        set_in(7'b0);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("reset.state", 32'(state), 32'd0);
        chk("reset.outs", 32'(outs_now()), 32'd0);
        chk("reset.retired", 32'(retired), 32'd0);
        rst_b = 1'b1;

        // ALU op, LW with 3 waits, SW with read+write both set
        for (int i = 0; i < 20; i++)
            apply_v($sformatf("row%0d", i), tbl[i].in, tbl[i].st, tbl[i].outs);
        chk("table.retired", 32'(retired), 32'd3);

        // MULT: alu_done five cycles after alu_start
        apply_v("mult.fetch", 7'b0000010, 3'd1, 9'b100100000);
        apply_v("mult.decode", 7'b1001000, 3'd2, 9'b000000000);
        n_exec = 0;
        n_start = 0;
        for (int i = 0; i < 20; i++) begin
            set_in({6'b100100, (i == 5)});
            #1;
            if (state != 3'd3) break;
            n_exec++;
            n_start += int'(alu_start);
            @(posedge clk);
            #1;
        end
        chk("mult.exec_cycles", 32'(n_exec), 32'd6);
        chk("mult.start_pulses", 32'(n_start), 32'd1);
        chk("mult.wb_state", 32'(state), 32'd5);
        chk("mult.wb_outs", 32'(outs_now()), 32'(9'b000001100));
        @(posedge clk);
        #1;
        chk("mult.retired", 32'(retired), 32'd4);

        // FETCH timeout: ack never arrives
        set_in(7'b0);
        n_wait = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (state != 3'd1) break;
            n_wait++;
            @(posedge clk);
            #1;
        end
        chk("timeout.wait_cycles", 32'(n_wait), 32'd15);
        chk("timeout.state", 32'(state), 32'd7);
        chk("timeout.outs", 32'(outs_now()), 32'(9'b000000001));
        @(posedge clk);
        #1;
        apply_v("fault.ack_ignored", 7'b0000011, 3'd7, 9'b000000001);
        apply_v("fault.sticky", 7'b0000000, 3'd7, 9'b000000001);

        // ack on the terminal wait cycle wins, then syscall halt
        do_reset();
        apply_v("to15.rst", 7'b0000000, 3'd0, 9'b000000000);
        for (int i = 1; i < 15; i++)
            apply_v($sformatf("to15.wait%0d", i), 7'b0000000, 3'd1, 9'b100000000);
        apply_v("to15.ack", 7'b0000010, 3'd1, 9'b100100000);
        apply_v("halt.decode", 7'b0000100, 3'd2, 9'b000000000);
        apply_v("halt.ack", 7'b0000010, 3'd6, 9'b000000010);
        apply_v("halt.done", 7'b0000001, 3'd6, 9'b000000010);
        apply_v("halt.both", 7'b1100011, 3'd6, 9'b000000010);
        chk("halt.retired", 32'(retired), 32'd0);

        // reset asserted mid-MEM
        do_reset();
        apply_v("mr.rst", 7'b0000000, 3'd0, 9'b000000000);
        apply_v("mr.f0", 7'b1000010, 3'd1, 9'b100100000);
        apply_v("mr.d0", 7'b1000000, 3'd2, 9'b000000000);
        apply_v("mr.e0", 7'b1000000, 3'd3, 9'b000010000);
        apply_v("mr.w0", 7'b1000000, 3'd5, 9'b000001100);
        chk("mr.retired1", 32'(retired), 32'd1);
        apply_v("mr.f1", 7'b1100010, 3'd1, 9'b100100000);
        apply_v("mr.d1", 7'b1100000, 3'd2, 9'b000000000);
        apply_v("mr.e1", 7'b1100000, 3'd3, 9'b000010000);
        apply_v("mr.mem", 7'b1100000, 3'd4, 9'b110000000);
        rst_b = 1'b0;
        #1;
        chk("mr.async_state", 32'(state), 32'd0);
        chk("mr.async_outs", 32'(outs_now()), 32'd0);
        chk("mr.async_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        set_in(7'b0);
        apply_v("mr.rel", 7'b0000000, 3'd0, 9'b000000000);
        apply_v("mr.fetch", 7'b0000000, 3'd1, 9'b100000000);
        chk("mr.retired0", 32'(retired), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
